// File: rtl/bubble_pkg.sv
// rtl/bubble_pkg.sv - shared codes, FSM states and limits for the bubble output engine
package bubble_pkg;

  localparam logic [2:0] ACC_BOOT_RD = 3'b001;
  localparam logic [2:0] ACC_USER_RD = 3'b010;

  localparam logic IDLE_LVL_DEFAULT = 1'b0;
  localparam int   MAX_CH_NUM       = 4;
  localparam int   MAX_BITS_PER_CH  = 8192;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_STREAM
  } state_t;

  function automatic logic is_streaming(input logic [2:0] acc);
    return (acc == ACC_BOOT_RD) || (acc == ACC_USER_RD);
  endfunction

endpackage

// File: rtl/bubble_pingpong_ram.sv
// rtl/bubble_pingpong_ram.sv - two-bank page store, 1-bit write port, CH_NUM-bit registered read port
module bubble_pingpong_ram #(
  parameter int CH_NUM      = 2,
  parameter int BITS_PER_CH = 1024,
  parameter int AW          = 11,
  parameter int IW          = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [IW-1:0]     rd_idx,
  output logic [CH_NUM-1:0] rd_data
);

  logic [AW-1:0] wr_ch;
  logic [IW-1:0] wr_bit;

  // Channel field above the bit index; values >= CH_NUM match no channel and are dropped.
  assign wr_ch  = wr_addr >> IW;
  assign wr_bit = wr_addr[IW-1:0];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic mem [0:2*BITS_PER_CH-1];
    logic q;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_ch == AW'(c))) begin
        mem[{wr_bank, wr_bit}] <= wr_data;
      end
      if (rd_en) begin
        q <= mem[{rd_bank, rd_idx}];
      end
    end

    assign rd_data[c] = q;
  end

endmodule

// File: rtl/bubble_output_engine.sv
// rtl/bubble_output_engine.sv - ping-pong page buffer serialised onto CH_NUM DOUT lines
// Optional BUBBLE_SWAP_EN adds nSWAPEN for reversed channel order.
module bubble_output_engine import bubble_pkg::*; #(
  parameter int   CH_NUM      = 2,
  parameter int   BITS_PER_CH = 1024,
  parameter logic IDLE_LVL    = IDLE_LVL_DEFAULT
) (
  input  logic                                   MCLK,
  input  logic                                   RST,
  input  logic [2:0]                             ACCTYPE,
  input  logic [12:0]                            BOUTCYCLENUM,
  input  logic                                   nBOUTCLKEN,
  input  logic                                   nOUTBUFWCLKEN,
  input  logic [$clog2(CH_NUM*BITS_PER_CH)-1:0]  OUTBUFWADDR,
  input  logic                                   OUTBUFWDATA,
  input  logic                                   PAGECOMMIT,
`ifdef BUBBLE_SWAP_EN
  input  logic                                   nSWAPEN,
`endif
  output logic [CH_NUM-1:0]                      DOUT,
  output logic                                   BANKSEL,
  output logic                                   PENDING,
  output logic                                   DROP,
  output logic                                   OVRN
);

  localparam int AW = $clog2(CH_NUM*BITS_PER_CH);
  localparam int IW = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;

  state_t            state;
  logic              stream;
  logic              rd_live;
  logic              rd_en;
  logic              rd_oor;
  logic              swap_req;
  logic [IW-1:0]     rd_idx;
  logic [CH_NUM-1:0] ram_q;
  logic [CH_NUM-1:0] ram_rev;
  logic              s1_live;
  logic              s1_vld;
  logic              s1_oor;
  logic              s1_rev;

  assign stream  = is_streaming(ACCTYPE);
  assign rd_live = (state == ST_STREAM) && stream;
  assign rd_en   = rd_live && !nBOUTCLKEN;
  assign rd_oor  = {1'b0, BOUTCYCLENUM} >= 14'(BITS_PER_CH);
  assign rd_idx  = BOUTCYCLENUM[IW-1:0];

`ifdef BUBBLE_SWAP_EN
  assign swap_req = ~nSWAPEN;
`else
  assign swap_req = 1'b0;
`endif

  bubble_pingpong_ram #(
    .CH_NUM      (CH_NUM),
    .BITS_PER_CH (BITS_PER_CH),
    .AW          (AW),
    .IW          (IW)
  ) u_ram (
    .clk     (MCLK),
    .wr_en   (!nOUTBUFWCLKEN),
    .wr_bank (~BANKSEL),
    .wr_addr (OUTBUFWADDR),
    .wr_data (OUTBUFWDATA),
    .rd_en   (rd_en),
    .rd_bank (BANKSEL),
    .rd_idx  (rd_idx),
    .rd_data (ram_q)
  );

  for (genvar i = 0; i < CH_NUM; i++) begin : g_rev
    assign ram_rev[i] = ram_q[CH_NUM-1-i];
  end

  // A commit landing on the stream-end cycle is resolved after the end: one swap only.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      BANKSEL <= 1'b0;
      PENDING <= 1'b0;
      DROP    <= 1'b0;
      OVRN    <= 1'b0;
    end else begin
      DROP <= 1'b0;
      if (rd_en && rd_oor) begin
        OVRN <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (PAGECOMMIT) begin
            BANKSEL <= ~BANKSEL;
            state   <= ST_READY;
          end
        end
        ST_READY: begin
          if (PAGECOMMIT) begin
            BANKSEL <= ~BANKSEL;
          end
          if (stream) begin
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!stream) begin
            if (PENDING) begin
              BANKSEL <= ~BANKSEL;
              PENDING <= 1'b0;
              DROP    <= PAGECOMMIT;
              state   <= ST_READY;
            end else if (PAGECOMMIT) begin
              BANKSEL <= ~BANKSEL;
              state   <= ST_READY;
            end else begin
              state <= ST_IDLE;
            end
          end else if (PAGECOMMIT) begin
            if (PENDING) begin
              DROP <= 1'b1;
            end else begin
              PENDING <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1 tracks the RAM read; stage 2 is the output register.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      s1_live <= 1'b0;
      s1_vld  <= 1'b0;
      s1_oor  <= 1'b0;
      s1_rev  <= 1'b0;
      DOUT    <= {CH_NUM{IDLE_LVL}};
    end else begin
      s1_live <= rd_live;
      s1_vld  <= rd_en;
      s1_oor  <= rd_oor;
      s1_rev  <= swap_req;
      if (!s1_live || (s1_vld && s1_oor)) begin
        DOUT <= {CH_NUM{IDLE_LVL}};
      end else if (s1_vld) begin
        DOUT <= s1_rev ? ram_rev : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_bubble_output_engine.sv
// tb/tb_bubble_output_engine.sv - randomized scoreboard bench for bubble_output_engine
`timescale 1ns/1ps
module tb_bubble_output_engine;

  localparam int   CH   = 2;
  localparam int   BITS = 64;
  localparam int   AW   = $clog2(CH*BITS);
  localparam logic IDLE = 1'b0;

  logic          MCLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    ACCTYPE = 3'b000;
  logic [12:0]   BOUTCYCLENUM = '0;
  logic          nBOUTCLKEN = 1'b1;
  logic          nOUTBUFWCLKEN = 1'b1;
  logic [AW-1:0] OUTBUFWADDR = '0;
  logic          OUTBUFWDATA = 1'b0;
  logic          PAGECOMMIT = 1'b0;
`ifdef BUBBLE_SWAP_EN
  logic          nSWAPEN = 1'b1;
`endif
  logic [CH-1:0] DOUT;
  logic          BANKSEL, PENDING, DROP, OVRN;

  always #5 MCLK = ~MCLK;

  bubble_output_engine #(.CH_NUM(CH), .BITS_PER_CH(BITS), .IDLE_LVL(IDLE)) dut (
    .MCLK(MCLK), .RST(RST), .ACCTYPE(ACCTYPE), .BOUTCYCLENUM(BOUTCYCLENUM),
    .nBOUTCLKEN(nBOUTCLKEN), .nOUTBUFWCLKEN(nOUTBUFWCLKEN), .OUTBUFWADDR(OUTBUFWADDR),
    .OUTBUFWDATA(OUTBUFWDATA), .PAGECOMMIT(PAGECOMMIT),
`ifdef BUBBLE_SWAP_EN
    .nSWAPEN(nSWAPEN),
`endif
    .DOUT(DOUT), .BANKSEL(BANKSEL), .PENDING(PENDING), .DROP(DROP), .OVRN(OVRN)
  );

  typedef enum int {K_DOUT, K_BANK, K_PEND, K_DROP, K_OVRN} kind_e;
  typedef struct {
    int            due;
    kind_e         kind;
    logic [CH-1:0] val;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  // Reference state: page contents per bank, which bank is on the pins, session phase.
  logic          mem_m [2][CH][BITS];
  int            front = 0;
  int            pending = 0;
  int            phase = 0;
  logic          ovrn_m = 1'b0;
  logic [CH-1:0] last_dout = '0;
  logic          swp = 1'b1;

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic void push(input int due, input kind_e k, input logic [CH-1:0] v);
    exp_t e;
    e.due = due; e.kind = k; e.val = v;
    sbq.push_back(e);
  endfunction

  always @(negedge MCLK) begin
    exp_t          e;
    logic [CH-1:0] act;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      case (e.kind)
        K_DOUT:  act = DOUT;
        K_BANK:  act = CH'(BANKSEL);
        K_PEND:  act = CH'(PENDING);
        K_DROP:  act = CH'(DROP);
        default: act = CH'(OVRN);
      endcase
      n_checks++;
      if (act !== e.val || e.due != cyc) begin
        n_fails++;
        $display("FAIL %s cyc=%0d due=%0d actual=%b required=%b", e.kind.name(), cyc, e.due, act, e.val);
      end
    end
  end

  task automatic step(input logic rst, input logic [2:0] acc, input logic strobe, input int idx,
                      input logic commit, input logic we, input int waddr, input logic wdata);
    int            n;
    logic          strm, live, rev, drop;
    logic [CH-1:0] dnext;
    RST = rst; ACCTYPE = acc; nBOUTCLKEN = ~strobe; BOUTCYCLENUM = 13'(idx);
    PAGECOMMIT = commit; nOUTBUFWCLKEN = ~we; OUTBUFWADDR = AW'(waddr); OUTBUFWDATA = wdata;
    rev = 1'b0;
`ifdef BUBBLE_SWAP_EN
    nSWAPEN = swp;
    rev = ~swp;
`endif
    n = cyc;
    strm = (acc == 3'b001) || (acc == 3'b010);
    if (rst) begin
      while (sbq.size() > 0 && sbq[$].due > n) void'(sbq.pop_back());
      front = 0; pending = 0; phase = 0; ovrn_m = 1'b0; last_dout = {CH{IDLE}};
      push(n+1, K_DOUT, last_dout);
      push(n+1, K_BANK, '0); push(n+1, K_PEND, '0); push(n+1, K_DROP, '0); push(n+1, K_OVRN, '0);
      push(n+2, K_DOUT, last_dout);
    end else begin
      live = (phase == 2) && strm;
      if (live && strobe) begin
        if (idx >= BITS) begin
          dnext = {CH{IDLE}};
          ovrn_m = 1'b1;
        end else begin
          for (int i = 0; i < CH; i++) dnext[i] = mem_m[front][rev ? CH-1-i : i][idx];
        end
      end else if (!live) begin
        dnext = {CH{IDLE}};
      end else begin
        dnext = last_dout;
      end
      last_dout = dnext;
      if (we && (waddr / BITS) < CH) mem_m[1-front][waddr/BITS][waddr%BITS] = wdata;
      drop = 1'b0;
      if (phase == 0) begin
        if (commit) begin front = 1 - front; phase = 1; end
      end else if (phase == 1) begin
        if (commit) front = 1 - front;
        if (strm) phase = 2;
      end else if (!strm) begin
        if (pending != 0) begin front = 1 - front; pending = 0; drop = commit; phase = 1; end
        else if (commit) begin front = 1 - front; phase = 1; end
        else phase = 0;
      end else if (commit) begin
        if (pending != 0) drop = 1'b1;
        else pending = 1;
      end
      push(n+1, K_BANK, CH'(front)); push(n+1, K_PEND, CH'(pending));
      push(n+1, K_DROP, CH'(drop));  push(n+1, K_OVRN, CH'(ovrn_m));
      push(n+2, K_DOUT, dnext);
    end
    @(posedge MCLK); #1;
  endtask

  task automatic st(input logic [2:0] acc, input logic strobe, input int idx, input logic commit);
    step(1'b0, acc, strobe, idx, commit, 1'b0, 0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] acc, input int addr, input logic d);
    step(1'b0, acc, 1'b0, 0, 1'b0, 1'b1, addr, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [2:0] acc;
    logic       cm;
    pat = 8'hA5;
    @(posedge MCLK); #1;
    step(1'b1, 3'b000, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 3'b000, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    for (int a = 0; a < CH*BITS; a++)
      wr(3'b000, a, (a < 8) ? pat[7-a] : 1'($urandom_range(0, 1)));
    st(3'b000, 1'b0, 0, 1'b1);
    for (int a = 0; a < CH*BITS; a++) wr(3'b000, a, 1'($urandom_range(0, 1)));
    st(3'b010, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      st(3'b010, 1'b1, i, 1'b0);
      step(1'b0, 3'b010, 1'b0, 0, 1'b0, 1'b1, $urandom_range(0, CH*BITS-1), 1'($urandom_range(0, 1)));
    end
    st(3'b010, 1'b1, BITS-1, 1'b1);
    st(3'b010, 1'b0, 0, 1'b0);
    st(3'b010, 1'b1, 3, 1'b0);
    st(3'b000, 1'b0, 0, 1'b0);
    st(3'b000, 1'b0, 0, 1'b0);
    st(3'b001, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) st(3'b001, 1'b1, $urandom_range(0, BITS-1), i == 1 || i == 2);
    st(3'b001, 1'b0, 0, 1'b0);
    st(3'b100, 1'b1, 5, 1'b0);
    st(3'b000, 1'b0, 0, 1'b0);
    st(3'b010, 1'b0, 0, 1'b0);
    st(3'b010, 1'b1, 9, 1'b0);
    st(3'b000, 1'b0, 0, 1'b1);
    st(3'b001, 1'b0, 0, 1'b0);
    st(3'b001, 1'b1, BITS-1, 1'b0);
    st(3'b001, 1'b1, BITS, 1'b0);
    st(3'b001, 1'b0, 0, 1'b0);
    st(3'b001, 1'b1, 8191, 1'b0);
    st(3'b001, 1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) st(3'b001, 1'b0, 0, 1'b0);
    swp = 1'b0;
    for (int i = 0; i < 4; i++) st(3'b010, 1'b1, i, 1'b0);
    swp = 1'b1;
    st(3'b010, 1'b1, 1, 1'b0);
    acc = 3'b010;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) acc = 3'($urandom_range(0, 7));
      swp = ($urandom_range(0, 3) != 0);
      cm = ($urandom_range(0, 9) == 0);
      if (phase == 2 && pending != 0 && !(acc == 3'b001 || acc == 3'b010)) cm = 1'b0;
      step(1'b0, acc, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? $urandom_range(BITS, 8191) : $urandom_range(0, BITS-1),
           cm, 1'($urandom_range(0, 1)), $urandom_range(0, CH*BITS-1), 1'($urandom_range(0, 1)));
    end
    swp = 1'b1;
    step(1'b1, 3'b000, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    st(3'b000, 1'b0, 0, 1'b1);
    st(3'b010, 1'b0, 0, 1'b0);
    st(3'b010, 1'b1, 4, 1'b0);
    st(3'b010, 1'b1, 6, 1'b1);
    step(1'b1, 3'b010, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0);
    st(3'b010, 1'b1, 1, 1'b0);
    st(3'b000, 1'b0, 0, 1'b0);
    repeat (3) @(posedge MCLK);
    @(negedge MCLK); #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fails++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
